// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter over 8 requesters with a bounded grant tenure.
// Each grant is followed by exactly one dead cycle before the next grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant and no pending changeover; arbitrate on any request
// GRANT   | gnt/gnt_idx valid; hold while req[gnt_idx] and tenure remain
// RELEASE | one dead cycle (gnt=0); arbitrate with the advanced pointer
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   req[7:0]  request vector, bit i = requester i
//   gnt[7:0]  registered one-hot grant, zero when none
//   gnt_idx   binary index of the granted requester (valid with gnt_valid)
//   gnt_valid high while a grant is active (|gnt)
//   expire    one-cycle pulse when a grant is forced off at the tenure limit
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expire
);

  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state, nxt_state;
  logic [2:0]      ptr, nxt_ptr;
  logic [2:0]      idx_q, nxt_idx;
  logic [7:0]      gnt_q, nxt_gnt;
  logic            exp_q, nxt_exp;
  logic [CW-1:0]   hold_cnt, nxt_hold;
  logic [2:0]      win;

  // First set request scanning from ptr upward; iterating from the far end
  // downward lets the closest candidate overwrite the others.
  always_comb begin
    win = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) win = ptr + 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      idx_q    <= 3'd0;
      gnt_q    <= 8'h00;
      exp_q    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      idx_q    <= nxt_idx;
      gnt_q    <= nxt_gnt;
      exp_q    <= nxt_exp;
      hold_cnt <= nxt_hold;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_idx   = idx_q;
    nxt_gnt   = gnt_q;
    nxt_exp   = 1'b0;
    nxt_hold  = hold_cnt;
    case (state)
      IDLE, RELEASE: begin
        if (|req) begin
          nxt_state = GRANT;
          nxt_gnt   = 8'h01 << win;
          nxt_idx   = win;
          nxt_hold  = '0;
        end else begin
          nxt_state = IDLE;
          nxt_gnt   = 8'h00;
        end
      end
      GRANT: begin
        if (!req[idx_q] || (HOLD_MAX != 0 && hold_cnt == HOLD_LAST)) begin
          // Expire only when the requester still wanted the resource.
          nxt_exp   = req[idx_q];
          nxt_gnt   = 8'h00;
          nxt_ptr   = idx_q + 3'd1;
          nxt_state = RELEASE;
        end else if (hold_cnt != '1) begin
          // Saturate so unlimited tenure never wraps the counter.
          nxt_hold = hold_cnt + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_gnt   = 8'h00;
      end
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = |gnt_q;
    expire    = exp_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req16 = 8'h00, req1 = 8'h00, req4 = 8'h00, req0 = 8'h00;
  logic [7:0] gnt16, gnt1, gnt4, gnt0;
  logic [2:0] idx16, idx1, idx4, idx0;
  logic       val16, val1, val4, val0;
  logic       exp16, exp1, exp4, exp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(16)) u16 (.clk(clk), .rst(rst), .req(req16), .gnt(gnt16),
                                    .gnt_idx(idx16), .gnt_valid(val16), .expire(exp16));
  rr_arbiter8 #(.HOLD_MAX(1))  u1  (.clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
                                    .gnt_idx(idx1), .gnt_valid(val1), .expire(exp1));
  rr_arbiter8 #(.HOLD_MAX(4))  u4  (.clk(clk), .rst(rst), .req(req4), .gnt(gnt4),
                                    .gnt_idx(idx4), .gnt_valid(val4), .expire(exp4));
  rr_arbiter8 #(.HOLD_MAX(0))  u0  (.clk(clk), .rst(rst), .req(req0), .gnt(gnt0),
                                    .gnt_idx(idx0), .gnt_valid(val0), .expire(exp0));

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       exp;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // HOLD_MAX=16 sequence: single requester, ptr advance, wrap 6->7->0, masking
    tbl[0]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[1]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[2]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[3]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[4]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[7]  = '{8'h0F, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    tbl[10] = '{8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
    tbl[12] = '{8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
    tbl[13] = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[14] = '{8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
    tbl[15] = '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[16] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[17] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[18] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
    tbl[19] = '{8'hFE, 8'h02, 3'd1, 1'b1, 1'b0};
    tbl[20] = '{8'hFC, 8'h00, 3'd1, 1'b0, 1'b0};
    tbl[21] = '{8'hFC, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[22] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[23] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};

    // reset state
    tick();
    tick();
    chk("rst_gnt16", {24'h0, gnt16}, 32'h0);
    chk("rst_idx16", {29'h0, idx16}, 32'h0);
    chk("rst_val16", {31'h0, val16}, 32'h0);
    chk("rst_exp16", {31'h0, exp16}, 32'h0);
    chk("rst_gnt_all", {gnt1, gnt4, gnt0, 8'h0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 24; i++) begin
      req16 = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_gnt", i), {24'h0, gnt16}, {24'h0, tbl[i].gnt});
      chk($sformatf("tbl%0d_idx", i), {29'h0, idx16}, {29'h0, tbl[i].idx});
      chk($sformatf("tbl%0d_val", i), {31'h0, val16}, {31'h0, tbl[i].valid});
      chk($sformatf("tbl%0d_exp", i), {31'h0, exp16}, {31'h0, tbl[i].exp});
    end

    // HOLD_MAX=1, everyone requesting: 0..7,0 with a dead cycle + expire each time
    req1 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("h1_gnt%0d", i), {24'h0, gnt1}, 32'h1 << (i % 8));
      chk($sformatf("h1_idx%0d", i), {29'h0, idx1}, i % 8);
      chk($sformatf("h1_exp_on_grant%0d", i), {31'h0, exp1}, 32'h0);
      tick();
      chk($sformatf("h1_dead%0d", i), {24'h0, gnt1}, 32'h0);
      chk($sformatf("h1_expire%0d", i), {31'h0, exp1}, 32'h1);
    end
    req1 = 8'h00;

    // HOLD_MAX=4, req=03: 0 x4, expire, 1 x4, expire, then 0 again
    req4 = 8'h03;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("h4_r%0d_c%0d_gnt", r, c), {24'h0, gnt4}, 32'h1 << (r % 2));
        chk($sformatf("h4_r%0d_c%0d_exp", r, c), {31'h0, exp4}, 32'h0);
      end
      tick();
      chk($sformatf("h4_r%0d_dead", r), {24'h0, gnt4}, 32'h0);
      chk($sformatf("h4_r%0d_expire", r), {31'h0, exp4}, 32'h1);
    end
    req4 = 8'h00;

    // HOLD_MAX=0: unlimited tenure for requester 0 while 7 waits
    req0 = 8'h81;
    tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      chk($sformatf("h0_gnt%0d", c), {24'h0, gnt0}, 32'h01);
      chk($sformatf("h0_exp%0d", c), {31'h0, exp0}, 32'h0);
    end
    req0 = 8'h00;

    // async reset mid-grant; first move ptr to 5 so the post-reset grant shows ptr=0
    req16 = 8'h10;
    tick();
    chk("ar_gnt4", {24'h0, gnt16}, 32'h10);
    req16 = 8'h00;
    tick();
    req16 = 8'h20;
    tick();
    chk("ar_gnt5", {24'h0, gnt16}, 32'h20);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_async_gnt", {24'h0, gnt16}, 32'h0);
    chk("ar_async_val", {31'h0, val16}, 32'h0);
    chk("ar_async_exp", {31'h0, exp16}, 32'h0);
    req16 = 8'h30;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_first_gnt", {24'h0, gnt16}, 32'h10);
    chk("ar_first_idx", {29'h0, idx16}, 32'h4);
    chk("ar_first_val", {31'h0, val16}, 32'h1);
    req16 = 8'h00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource between 8 requesters.
- Produces a registered one-hot grant and its 3-bit index, so downstream logic can use either form.
- A grant is held while its requester keeps requesting, up to a bounded tenure.
- Between any two grants there is exactly one dead cycle (grant all-zero), giving downstream muxes a clean changeover.

Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one grant may be held; 0 = unlimited tenure.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- gnt  output  8  registered one-hot grant; all-zero when no grant
- gnt_idx  output  3  binary index of the granted requester; valid only while gnt_valid=1
- gnt_valid  output  1  high while any grant is active (equals |gnt)
- expire  output  1  one-cycle pulse: a grant was force-released at tenure limit while its req was still high

Behaviour:
- Reset (async on rst high, held until rst low):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, expire=0.
  - state=IDLE, priority pointer ptr=3'd0, hold_cnt=0.
- Arbitration (combinational winner in IDLE and RELEASE):
  - Winner is the first set bit of req scanning ptr, ptr+1, ..., ptr+7, modulo 8.
  - The 7->0 wrap is natural 3-bit overflow.
- States:
  - IDLE:
    - If req != 0 at a rising edge: load gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0; go to GRANT.
    - Otherwise stay in IDLE.
    - Latency: req sampled at edge k gives gnt visible after edge k.
  - GRANT: at each edge, evaluated in this order:
    - If req[gnt_idx]=0: release (no expire).
    - Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1: release and pulse expire=1 for exactly one cycle.
    - Else: hold_cnt++ and keep the grant.
    - On release: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 8), go to RELEASE.
    - gnt_idx holds its last value.
  - RELEASE (exactly one cycle, gnt=0):
    - Arbitrate using the updated ptr.
    - If req != 0: grant the winner at the next edge, go to GRANT.
    - Else: go to IDLE.
- Tenure:
  - A grant is visible for at most HOLD_MAX cycles.
  - HOLD_MAX=1 means a single-cycle grant, followed by RELEASE.
  - hold_cnt width is max(1, clog2(HOLD_MAX+1)) bits and must never wrap.
- Fairness:
  - After an expiry the expired requester becomes lowest priority.
  - If it keeps requesting, it is re-granted only after every other active requester has been served once.
  - If no other requester is active, it is re-granted right after the dead cycle.
- Masking:
  - Changes on req bits other than gnt_idx during GRANT have no effect on the current grant.
  - req rising in the same cycle the current grant's req drops is considered in RELEASE, not earlier.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt==(1<<gnt_idx) whenever gnt_valid=1.
  - expire is never high in IDLE.
  - expire is never high in two consecutive cycles.
- Reset mid-grant:
  - gnt, gnt_valid and expire drop immediately, without waiting for a clock edge.
  - ptr returns to 0.
  - The first grant after rst deasserts follows normal IDLE rules.

Test Plan:
- Single requester, HOLD_MAX=16: req=8'h04 held for 5 cycles then dropped.
  - gnt=8'h04, gnt_idx=2 for 5 cycles.
  - One RELEASE cycle with gnt=0, then IDLE; ptr=3.
- All requesting, HOLD_MAX=1: req=8'hFF held.
  - Grant sequence 0,1,2,...,7,0 with one zero cycle between each.
  - expire pulses on every release.
- Pointer wrap: grant requester 6 and release; then req=8'h81.
  - Next grant is index 7 (ptr=7), then index 0.
- Tenure limit, HOLD_MAX=4: req=8'h03 held.
  - gnt=8'h01 for 4 cycles, expire=1 for one cycle, dead cycle.
  - Then gnt=8'h02 for 4 cycles, expire, dead cycle, then gnt=8'h01.
- Unlimited tenure, HOLD_MAX=0: req=8'h01 held 100 cycles while req[7] also high.
  - gnt stays 8'h01 for all 100 cycles; expire never asserts.
- Async reset: assert rst mid-GRANT between clock edges.
  - gnt=0 and gnt_valid=0 immediately.
  - After release with req=8'h30: first grant is index 4.
